// File: rtl/branch_compare_seq_if.sv
// branch_compare_seq_if: request/result handshake bundle for the sequential branch comparator
interface branch_compare_seq_if #(parameter int WIDTH = 32);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [2:0]       op_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             taken_o;
  logic             eq_o;
  logic             lt_o;
  logic             ltu_o;
  logic             illegal_o;
  modport slave (
    input  in_valid_i, a_i, b_i, op_i, out_ready_i,
    output in_ready_o, out_valid_o, taken_o, eq_o, lt_o, ltu_o, illegal_o
  );
  modport master (
    output in_valid_i, a_i, b_i, op_i, out_ready_i,
    input  in_ready_o, out_valid_o, taken_o, eq_o, lt_o, ltu_o, illegal_o
  );
endinterface

// File: rtl/branch_compare_seq.sv
// branch_compare_seq: MSB-first sliced comparator producing eq/lt/ltu and a funct3 branch decision
module branch_compare_seq #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 4,
  parameter int EARLY_EXIT = 1
) (
  input logic clk_i,
  input logic rst_i,
  branch_compare_seq_if.slave bus
);
  localparam int NUM_CHUNKS = WIDTH / CHUNK;
  localparam int CW = NUM_CHUNKS > 1 ? $clog2(NUM_CHUNKS) : 1;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b;
  logic [2:0]       r_op;
  logic             r_sa, r_sb;
  logic [CW-1:0]    r_cnt;
  logic             r_found, r_ltu_l;
  logic             r_eq, r_lt, r_ltu, r_taken, r_illegal;
  logic [CHUNK-1:0] w_as, w_bs;
  logic             w_diff, w_last, w_ltu, w_eq, w_lt, w_illegal, w_taken;
  // operands shift left each scan cycle, so the current slice is always the top CHUNK bits
  assign w_as      = r_a[WIDTH-1 -: CHUNK];
  assign w_bs      = r_b[WIDTH-1 -: CHUNK];
  assign w_diff    = w_as != w_bs;
  assign w_last    = (EARLY_EXIT != 0 && w_diff) || r_cnt == '0;
  assign w_ltu     = r_found ? r_ltu_l : (w_diff && w_as < w_bs);
  assign w_eq      = !(r_found || w_diff);
  assign w_lt      = r_sa != r_sb ? r_sa : w_ltu;
  assign w_illegal = r_op[2:1] == 2'b01;
  assign w_taken   = w_illegal ? 1'b0 :
                     r_op[2] ? ((r_op[1] ? w_ltu : w_lt) ^ r_op[0]) : (w_eq ^ r_op[0]);
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (bus.in_valid_i ? SCAN : IDLE) :
             r_state == SCAN ? (w_last ? DONE : SCAN) :
             (bus.out_ready_i ? IDLE : DONE);
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_found   <= 1'b0;
      r_ltu_l   <= 1'b0;
      r_eq      <= 1'b0;
      r_lt      <= 1'b0;
      r_ltu     <= 1'b0;
      r_taken   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (r_state == IDLE && bus.in_valid_i) begin
      r_a     <= bus.a_i;
      r_b     <= bus.b_i;
      r_op    <= bus.op_i;
      r_sa    <= bus.a_i[WIDTH-1];
      r_sb    <= bus.b_i[WIDTH-1];
      r_cnt   <= CW'(NUM_CHUNKS - 1);
      r_found <= 1'b0;
      r_ltu_l <= 1'b0;
    end else if (r_state == SCAN) begin
      r_a   <= r_a << CHUNK;
      r_b   <= r_b << CHUNK;
      r_cnt <= r_cnt - 1'b1;
      if (!r_found && w_diff) begin
        r_found <= 1'b1;
        r_ltu_l <= w_as < w_bs;
      end
      if (w_last) begin
        r_eq      <= w_eq;
        r_lt      <= w_lt;
        r_ltu     <= w_ltu;
        r_taken   <= w_taken;
        r_illegal <= w_illegal;
      end
    end
  end
  assign bus.in_ready_o  = r_state == IDLE && !rst_i;
  assign bus.out_valid_o = r_state == DONE && !rst_i;
  assign bus.taken_o     = r_taken && !rst_i;
  assign bus.eq_o        = r_eq && !rst_i;
  assign bus.lt_o        = r_lt && !rst_i;
  assign bus.ltu_o       = r_ltu && !rst_i;
  assign bus.illegal_o   = r_illegal && !rst_i;
endmodule

// File: tb/tb_branch_compare_seq.sv
// tb_branch_compare_seq: directed and random checks of both early-exit and constant-latency builds
module tb_branch_compare_seq;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic sel = 1'b0;
  logic valid = 1'b0, ordy = 1'b0;
  logic [31:0] da = '0, db = '0;
  logic [2:0] dop = '0;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  branch_compare_seq_if #(.WIDTH(32)) if1 ();
  branch_compare_seq_if #(.WIDTH(32)) if0 ();
  branch_compare_seq #(.WIDTH(32), .CHUNK(4), .EARLY_EXIT(1)) u_ee (.clk_i(clk), .rst_i(rst_i), .bus(if1.slave));
  branch_compare_seq #(.WIDTH(32), .CHUNK(4), .EARLY_EXIT(0)) u_cl (.clk_i(clk), .rst_i(rst_i), .bus(if0.slave));
  assign if1.in_valid_i  = valid && !sel;
  assign if0.in_valid_i  = valid && sel;
  assign if1.out_ready_i = ordy && !sel;
  assign if0.out_ready_i = ordy && sel;
  assign if1.a_i = da;
  assign if0.a_i = da;
  assign if1.b_i = db;
  assign if0.b_i = db;
  assign if1.op_i = dop;
  assign if0.op_i = dop;
  logic ov, ir, tk, eq, lt, ltu, il;
  assign ov  = sel ? if0.out_valid_o : if1.out_valid_o;
  assign ir  = sel ? if0.in_ready_o  : if1.in_ready_o;
  assign tk  = sel ? if0.taken_o     : if1.taken_o;
  assign eq  = sel ? if0.eq_o        : if1.eq_o;
  assign lt  = sel ? if0.lt_o        : if1.lt_o;
  assign ltu = sel ? if0.ltu_o       : if1.ltu_o;
  assign il  = sel ? if0.illegal_o   : if1.illegal_o;

  task automatic chk(input string tg, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tg, obs, exp);
    end
  endtask

  function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input logic cl);
    if (cl || a == b) return 8;
    for (int i = 7; i >= 0; i--)
      if ((((a ^ b) >> (i * 4)) & 32'hF) != 0) return 8 - i;
    return 8;
  endfunction

  function automatic logic model_taken(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return $signed(a) < $signed(b);
      3'b101: return $signed(a) >= $signed(b);
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    int n = 0;
    @(negedge clk);
    da = a; db = b; dop = op; valid = 1'b1;
    while (!ir && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("issue_timeout", 32'(ir), 32'd1);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic expect_res(input string tg, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    int n = 0;
    while (!ov && n < 100) begin @(negedge clk); n++; end
    chk({tg, "_lat"}, 32'(n), 32'(model_lat(a, b, sel)));
    chk({tg, "_eq"}, 32'(eq), 32'(a == b));
    chk({tg, "_lt"}, 32'(lt), 32'($signed(a) < $signed(b)));
    chk({tg, "_ltu"}, 32'(ltu), 32'(a < b));
    chk({tg, "_taken"}, 32'(tk), 32'(model_taken(a, b, op)));
    chk({tg, "_illegal"}, 32'(il), 32'(op == 3'b010 || op == 3'b011));
    chk({tg, "_inready_busy"}, 32'(ir), 32'd0);
  endtask

  task automatic consume(input string tg);
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    chk({tg, "_ov_clear"}, 32'(ov), 32'd0);
    chk({tg, "_inready_back"}, 32'(ir), 32'd1);
  endtask

  task automatic run(input string tg, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    issue(a, b, op);
    expect_res(tg, a, b, op);
    consume(tg);
  endtask

  initial begin
    logic [6:0] snap;
    logic seen;
    logic [31:0] ra, rb;
    logic [2:0] rop;
    repeat (3) @(negedge clk);
    chk("rst_outputs", 32'({ir, ov, tk, eq, lt, ltu, il}), 32'd0);
    rst_i = 1'b0;
    @(negedge clk);
    chk("idle_ready", 32'(ir), 32'd1);
    run("beq_eq", 32'h5, 32'h5, 3'b000);
    run("bne_eq", 32'h5, 32'h5, 3'b001);
    run("blt_sign", 32'h8000_0000, 32'h1, 3'b100);
    run("bltu_sign", 32'h8000_0000, 32'h1, 3'b110);
    run("bgeu_sign", 32'h8000_0000, 32'h1, 3'b111);
    run("bgeu_s0", 32'h3, 32'h7, 3'b111);
    run("ones_zeros", 32'hFFFF_FFFF, 32'h0, 3'b101);
    run("signbit_only", 32'h0000_0000, 32'h8000_0000, 3'b100);
    // backpressure: result must hold while a new request waits upstream
    issue(32'h1234_5678, 32'h1234_5600, 3'b110);
    expect_res("bp", 32'h1234_5678, 32'h1234_5600, 3'b110);
    snap = {ov, tk, eq, lt, ltu, il, ir};
    da = 32'h1; db = 32'h2; dop = 3'b110; valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", 32'({ov, tk, eq, lt, ltu, il, ir}), 32'(snap));
    end
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    chk("bp_ready_after", 32'(ir), 32'd1);
    chk("bp_ov_clear", 32'(ov), 32'd0);
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    expect_res("bp_held_req", 32'h1, 32'h2, 3'b110);
    consume("bp_held_req");
    // reset in the middle of a scan discards the pending result
    issue(32'h3, 32'h7, 3'b111);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_ready", 32'(ir), 32'd0);
    chk("midrst_ov", 32'(ov), 32'd0);
    rst_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen |= ov;
    end
    chk("midrst_no_result", 32'(seen), 32'd0);
    chk("midrst_ready_after", 32'(ir), 32'd1);
    run("post_rst_blt", 32'hFFFF_FFFF, 32'h0, 3'b100);
    // constant-latency build
    sel = 1'b1;
    @(negedge clk);
    chk("cl_idle_ready", 32'(ir), 32'd1);
    run("cl_blt_sign", 32'h8000_0000, 32'h1, 3'b100);
    run("cl_illegal", 32'h1, 32'h1, 3'b010);
    run("cl_illegal3", 32'h9, 32'h1, 3'b011);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int k = 0; k < 40; k++) begin
        ra = $urandom;
        case ($urandom_range(0, 3))
          0: rb = $urandom;
          1: rb = ra;
          2: rb = ra ^ (32'h1 << $urandom_range(0, 31));
          default: rb = ~ra;
        endcase
        rop = 3'($urandom_range(0, 7));
        issue(ra, rb, rop);
        expect_res("rand", ra, rb, rop);
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          chk("rand_hold", 32'(ov), 32'd1);
        end
        consume("rand");
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
